// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter for sources A/B/C that drives the 3:1 mux select pair.
// Grants last up to MAX_HOLD cycles; all outputs are registered.
module mux_select_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       req_c,
  output logic [2:0] gnt,
  output logic       grant_vld,
  output logic       sel1,
  output logic       sel2
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;
  localparam logic [1:0] GNT_C = 2'd3;

  // Source indices double as the mux select code: A=00, B=01, C=10.
  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [1:0]       r_last;

  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] w_hold_cnt_next;
  logic [1:0]       w_last_next;
  logic [2:0]       w_req;
  logic [1:0]       w_cur_src;
  logic             w_cur_req;
  logic             w_release;

  // Pick the first requester after 'last' in A->B->C->A order; IDLE if none.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    case (last)
      SRC_A:   begin first = SRC_B; second = SRC_C; third = SRC_A; end
      SRC_B:   begin first = SRC_C; second = SRC_A; third = SRC_B; end
      default: begin first = SRC_A; second = SRC_B; third = SRC_C; end
    endcase
    if (req[first])       rr_pick = first + 2'd1;
    else if (req[second]) rr_pick = second + 2'd1;
    else if (req[third])  rr_pick = third + 2'd1;
    else                  rr_pick = IDLE;
  endfunction

  assign w_req     = {req_c, req_b, req_a};
  assign w_cur_src = r_state - 2'd1;

  always_comb begin
    w_cur_req = 1'b0;
    case (r_state)
      GNT_A:   w_cur_req = req_a;
      GNT_B:   w_cur_req = req_b;
      GNT_C:   w_cur_req = req_c;
      default: w_cur_req = 1'b0;
    endcase
  end

  assign w_release = (r_state != IDLE) && (!w_cur_req || (r_hold_cnt == HOLD_LAST));

  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt + 1'b1;
    w_last_next     = r_last;
    if (r_state == IDLE) begin
      w_hold_cnt_next = '0;
      w_state_next    = rr_pick(w_req, r_last);
    end else if (w_release) begin
      // Picking after the releasing source makes it lowest priority, and
      // re-grants it only when it is the sole requester.
      w_hold_cnt_next = '0;
      w_last_next     = w_cur_src;
      w_state_next    = rr_pick(w_req, w_cur_src);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_last     <= SRC_C;
      gnt        <= 3'b000;
      grant_vld  <= 1'b0;
      sel1       <= 1'b0;
      sel2       <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_last     <= w_last_next;
      grant_vld  <= (w_state_next != IDLE);
      case (w_state_next)
        GNT_A:   gnt <= 3'b001;
        GNT_B:   gnt <= 3'b010;
        GNT_C:   gnt <= 3'b100;
        default: gnt <= 3'b000;
      endcase
      // Selects hold through idle so the mux output does not glitch.
      if (w_state_next != IDLE) begin
        {sel1, sel2} <= w_state_next - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter (MAX_HOLD=4): reset, rotation,
// lone requester, short request, release priority and mid-burst reset.
module tb_mux_select_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic       req_c;
  logic [2:0] gnt;
  logic       grant_vld;
  logic       sel1;
  logic       sel2;

  int errors = 0;
  int checks = 0;

  mux_select_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .gnt       (gnt),
    .grant_vld (grant_vld),
    .sel1      (sel1),
    .sel2      (sel2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {gnt, grant_vld, sel1, sel2} against hand-computed values.
  task automatic chk(input string tag, input logic [2:0] e_gnt, input logic e_vld,
                     input logic [1:0] e_sel);
    logic [5:0] obs;
    logic [5:0] exp_v;
    obs   = {gnt, grant_vld, sel1, sel2};
    exp_v = {e_gnt, e_vld, e_sel};
    checks++;
    $display("check %-12s gnt=%b vld=%b sel=%b%b", tag, gnt, grant_vld, sel1, sel2);
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed gnt/vld/sel=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [2:0] rot_gnt [3];
    logic [1:0] rot_sel [3];
    rot_gnt[0] = 3'b001; rot_sel[0] = 2'b00;
    rot_gnt[1] = 3'b010; rot_sel[1] = 2'b01;
    rot_gnt[2] = 3'b100; rot_sel[2] = 2'b10;

    // 1: reset with all requests high
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; req_c = 1'b1;
    tick(); chk("reset0", 3'b000, 1'b0, 2'b00);
    tick(); chk("reset1", 3'b000, 1'b0, 2'b00);
    rst = 1'b0;

    // 2: full rotation, first grant is A on the first edge after reset
    for (int c = 0; c < 16; c++) begin
      tick();
      chk("rotate", rot_gnt[(c / 4) % 3], 1'b1, rot_sel[(c / 4) % 3]);
    end

    // 3: lone requester B is re-granted with no gap
    rst = 1'b1; req_a = 1'b0; req_b = 1'b1; req_c = 1'b0;
    tick(); chk("reset_b", 3'b000, 1'b0, 2'b00);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(); chk("lone_b", 3'b010, 1'b1, 2'b01);
    end
    req_b = 1'b0;
    tick(); chk("idle_selb", 3'b000, 1'b0, 2'b01);

    // 4: short request on A (last grant B, so A wins)
    req_a = 1'b1;
    tick(); chk("short_a0", 3'b001, 1'b1, 2'b00);
    tick(); chk("short_a1", 3'b001, 1'b1, 2'b00);
    req_a = 1'b0;
    tick(); chk("short_idle", 3'b000, 1'b0, 2'b00);
    tick(); chk("short_hold", 3'b000, 1'b0, 2'b00);

    // 5: C drops while A and B rise -> A then B
    req_c = 1'b1;
    tick(); chk("c_grant0", 3'b100, 1'b1, 2'b10);
    tick(); chk("c_grant1", 3'b100, 1'b1, 2'b10);
    req_c = 1'b0; req_a = 1'b1; req_b = 1'b1;
    tick(); chk("prio_a", 3'b001, 1'b1, 2'b00);
    req_a = 1'b0;
    tick(); chk("prio_b0", 3'b010, 1'b1, 2'b01);
    tick(); chk("prio_b1", 3'b010, 1'b1, 2'b01);
    tick(); chk("prio_b2", 3'b010, 1'b1, 2'b01);
    tick(); chk("prio_b3", 3'b010, 1'b1, 2'b01);
    // req_b drops on the same edge the hold count expires: single release to A
    req_b = 1'b0; req_a = 1'b1;
    tick(); chk("coinc_a", 3'b001, 1'b1, 2'b00);
    req_a = 1'b0;
    tick(); chk("coinc_idle", 3'b000, 1'b0, 2'b00);

    // 6: mid-burst reset while C is granted
    req_c = 1'b1;
    tick(); chk("mid_c0", 3'b100, 1'b1, 2'b10);
    tick(); chk("mid_c1", 3'b100, 1'b1, 2'b10);
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    tick(); chk("mid_rst", 3'b000, 1'b0, 2'b00);
    rst = 1'b0;
    tick(); chk("post_rst_a", 3'b001, 1'b1, 2'b00);
    tick(); chk("post_rst_a1", 3'b001, 1'b1, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
